// File: rtl/mem_loader.sv
// Byte-command loader for the instruction/data BRAM init ports; holds the CPU in reset until RUN.
// Write strobe 1 cycle after the last payload byte; readback valid RD_LAT+2 cycles after the last address byte; rx stalls while writing, reading or sending.
module mem_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] instr_mem_init_addr_o,
  output logic [DATA_W-1:0] instr_mem_init_data_o,
  output logic              instr_mem_init_enable_o,
  output logic [3:0]        instr_mem_init_we_o,
  output logic [ADDR_W-1:0] data_mem_init_addr_o,
  output logic [DATA_W-1:0] data_mem_init_data_o,
  input  logic [DATA_W-1:0] data_mem_init_data_i,
  output logic              data_mem_init_enable_o,
  output logic [3:0]        data_mem_init_we_o,
  input  logic              stop_i,
  output logic              cpu_reset_o,
  output logic              err_o
);

  localparam int WW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [1:0] C_WRI = 2'd1;
  localparam logic [1:0] C_WRD = 2'd2;
  localparam logic [1:0] C_RDD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_RREQ, S_RWAIT, S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [2:0]        tx_left_q, tx_left_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              err_q, err_d;
  logic              rx_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_buf_q    <= '0;
      tx_left_q   <= '0;
      wait_q      <= '0;
      rx_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_buf_q    <= tx_buf_d;
      tx_left_q   <= tx_left_d;
      wait_q      <= wait_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      err_q       <= err_d;
    end
  end

  assign rx_fire = rx_ready_q & rx_valid_i;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_buf_d    = tx_buf_q;
    tx_left_d   = tx_left_q;
    wait_d      = wait_q;
    cpu_reset_d = cpu_reset_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          case (rx_data_i)
            8'h01, 8'h02, 8'h03: begin
              cmd_d   = rx_data_i[1:0];
              cnt_d   = 2'd0;
              state_d = S_ADDR;
            end
            8'h04: cpu_reset_d = 1'b0;
            8'h05: cpu_reset_d = 1'b1;
            8'h06: begin
              tx_buf_d  = DATA_W'({6'b0, stop_i, cpu_reset_q});
              tx_left_d = 3'd1;
              state_d   = S_SEND;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          if (cnt_q == 2'd0) begin
            addr_d = ADDR_W'(rx_data_i);
            cnt_d  = 2'd1;
          end else begin
            // Bit 15 of the host address has no storage behind it.
            addr_d  = ADDR_W'({rx_data_i[6:0], addr_q[7:0]});
            cnt_d   = 2'd0;
            state_d = (cmd_q == C_RDD) ? S_RREQ : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          data_d = {rx_data_i, data_q[DATA_W-1:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RREQ: begin
        wait_d  = WW'(1);
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (wait_q == WW'(RD_LAT)) begin
          tx_buf_d  = data_mem_init_data_i;
          tx_left_d = 3'd4;
          state_d   = S_SEND;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_SEND: begin
        if (tx_ready_i) begin
          tx_buf_d  = tx_buf_q >> 8;
          tx_left_d = tx_left_q - 3'd1;
          if (tx_left_q == 3'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_valid_o  = (state_q == S_SEND);
  assign tx_data_o   = tx_buf_q[7:0];
  assign cpu_reset_o = cpu_reset_q;
  assign err_o       = err_q;

  assign instr_mem_init_addr_o   = addr_q;
  assign instr_mem_init_data_o   = data_q;
  assign instr_mem_init_enable_o = (state_q == S_WRITE) && (cmd_q == C_WRI);
  assign instr_mem_init_we_o     = {4{instr_mem_init_enable_o}};

  assign data_mem_init_addr_o    = addr_q;
  assign data_mem_init_data_o    = data_q;
  assign data_mem_init_we_o      = {4{(state_q == S_WRITE) && (cmd_q == C_WRD)}};
  assign data_mem_init_enable_o  = data_mem_init_we_o[0] || (state_q == S_RREQ);

endmodule

// File: tb/tb_mem_loader.sv
// Drives mem_loader with directed and random command streams; a packet-level model predicts writes, tx bytes and flags.
module tb_mem_loader;
  logic        clk;
  logic        reset;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [14:0] instr_addr, data_addr;
  logic [31:0] instr_wdata, data_wdata, data_rdata;
  logic        instr_en, data_en;
  logic [3:0]  instr_we, data_we;
  logic        stop_i, cpu_reset_o, err_o;

  mem_loader #(.ADDR_W(15), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .instr_mem_init_addr_o(instr_addr), .instr_mem_init_data_o(instr_wdata),
    .instr_mem_init_enable_o(instr_en), .instr_mem_init_we_o(instr_we),
    .data_mem_init_addr_o(data_addr), .data_mem_init_data_o(data_wdata),
    .data_mem_init_data_i(data_rdata), .data_mem_init_enable_o(data_en),
    .data_mem_init_we_o(data_we),
    .stop_i(stop_i), .cpu_reset_o(cpu_reset_o), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data-memory BRAM with one cycle of read latency.
  logic [31:0] bram [0:32767];
  always @(posedge clk) begin
    if (data_en) begin
      if (data_we == 4'hf) bram[data_addr] <= data_wdata;
      data_rdata <= bram[data_addr];
    end
  end

  // Reference model: packets are interpreted as whole byte lists.
  typedef struct packed {
    logic        dmem;
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [7:0]  pkt [$];
  logic [7:0]  seq [$];
  wr_t         exp_wr [$];
  logic [7:0]  exp_tx [$];
  logic [31:0] ref_dmem [int];
  int          waddrs [$];
  logic        m_cpu, m_err;

  task automatic model_byte(input logic [7:0] b);
    int a;
    logic [31:0] d;
    if (pkt.size() == 0) begin
      case (b)
        8'h01, 8'h02, 8'h03: pkt.push_back(b);
        8'h04: m_cpu = 1'b0;
        8'h05: m_cpu = 1'b1;
        8'h06: exp_tx.push_back({6'b0, stop_i, m_cpu});
        default: m_err = 1'b1;
      endcase
    end else begin
      pkt.push_back(b);
      if (pkt.size() >= 3) begin
        a = int'({pkt[2], pkt[1]}) % 32768;
        if (pkt[0] == 8'h03 && pkt.size() == 3) begin
          d = ref_dmem[a];
          for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
          pkt.delete();
        end else if (pkt.size() == 7) begin
          d = {pkt[6], pkt[5], pkt[4], pkt[3]};
          exp_wr.push_back('{dmem: (pkt[0] == 8'h02), addr: a[14:0], data: d});
          if (pkt[0] == 8'h02) begin
            ref_dmem[a] = d;
            waddrs.push_back(a);
          end
          pkt.delete();
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    model_byte(b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
    chk("cpu_reset", 32'(cpu_reset_o), 32'(m_cpu));
    chk("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_tx.size() + exp_wr.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("rst_tx", 32'({tx_valid_o, tx_data_o}), 32'd0);
    chk("rst_en", 32'({instr_en, instr_we, data_en, data_we}), 32'd0);
    chk("rst_addr", 32'({instr_addr, data_addr}), 32'd0);
    chk("rst_idata", instr_wdata, 32'd0);
    chk("rst_ddata", data_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
  endtask

  // Monitors: port-B strobes and the tx handshake.
  wr_t        w;
  logic       held = 1'b0;
  logic [7:0] held_b;
  logic [7:0] e;
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (instr_en || data_en) chk("dual_enable", 32'(instr_en & data_en), 32'd0);
      if (instr_en || (data_en && data_we != 4'h0)) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_mem", 32'(data_en), 32'(w.dmem));
          chk("wr_we", 32'(instr_en ? instr_we : data_we), 32'hf);
          chk("wr_addr", 32'(instr_en ? instr_addr : data_addr), 32'(w.addr));
          chk("wr_data", instr_en ? instr_wdata : data_wdata, w.data);
        end
      end
      if (tx_valid_o) begin
        if (held) chk("tx_stable", 32'(tx_data_o), 32'(held_b));
        if (tx_ready_i) begin
          held = 1'b0;
          if (exp_tx.size() == 0) begin
            chk("unexpected_tx", 32'd1, 32'd0);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", 32'(tx_data_o), 32'(e));
          end
        end else begin
          held   = 1'b1;
          held_b = tx_data_o;
        end
      end else if (held) begin
        chk("tx_valid_held", 32'd0, 32'd1);
        held = 1'b0;
      end
    end
  end

  // tx_ready_i modes: 0 always ready, 1 random, 2 repeating 1,0,0.
  int rdy_mode = 0;
  int rdy_ph   = 0;
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_ph = (rdy_ph + 1) % 3;
      case (rdy_mode)
        1:       tx_ready_i = 1'($urandom_range(0, 1));
        2:       tx_ready_i = (rdy_ph == 0);
        default: tx_ready_i = 1'b1;
      endcase
    end
  end

  initial begin
    logic [15:0] a16;
    logic [31:0] d;
    int k;
    reset = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; stop_i = 1'b0;
    m_cpu = 1'b1; m_err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("idle_err", 32'(err_o), 32'd0);
    chk("idle_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("idle_en", 32'({instr_en, instr_we, data_en, data_we}), 32'd0);

    seq = '{8'h01, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}; send_seq();
    seq = '{8'h02, 8'hFF, 8'hFF, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; send_seq();
    seq = '{8'h03, 8'hFF, 8'hFF}; send_seq();
    drain();
    rdy_mode = 2;
    seq = '{8'h03, 8'hFF, 8'h7F}; send_seq();
    drain();
    rdy_mode = 0;
    send_byte(8'h04);
    stop_i = 1'b1;
    send_byte(8'h06);
    drain();
    send_byte(8'h05);
    stop_i = 1'b0;
    send_byte(8'h06);
    drain();

    send_byte(8'h7A);
    send_byte(8'h04);
    send_byte(8'h06);
    drain();
    chk("err_sticky", 32'(err_o), 32'd1);

    seq = '{8'h01, 8'h0A, 8'h00, 8'h11}; send_seq();
    reset = 1'b1;
    pkt.delete(); m_cpu = 1'b1; m_err = 1'b0;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    seq = '{8'h02, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}; send_seq();
    seq = '{8'h03, 8'h01, 8'h80}; send_seq();
    drain();

    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      k = $urandom_range(0, 9);
      if ((k == 4 || k == 5) && waddrs.size() == 0) k = 2;
      case (k)
        0, 1: begin
          a16 = 16'($urandom); d = $urandom;
          seq = '{8'h01, a16[7:0], a16[15:8], d[7:0], d[15:8], d[23:16], d[31:24]};
        end
        2, 3, 9: begin
          a16 = 16'($urandom_range(0, 15));
          a16[15] = 1'($urandom_range(0, 1));
          d = $urandom;
          seq = '{8'h02, a16[7:0], a16[15:8], d[7:0], d[15:8], d[23:16], d[31:24]};
        end
        4, 5: begin
          a16 = 16'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
          a16[15] = 1'($urandom_range(0, 1));
          seq = '{8'h03, a16[7:0], a16[15:8]};
        end
        6: seq = '{8'($urandom_range(4, 5))};
        7: begin
          stop_i = 1'($urandom_range(0, 1));
          seq = '{8'h06};
        end
        default: seq = '{8'($urandom_range(7, 255))};
      endcase
      send_seq();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
